// File: rtl/spram_bridge_pkg.sv
// Shared types and helpers for the 32-bit to 16-bit SPRAM word bridge.
// Widths are fixed by the 16K x 16 SPRAM macro.
package spram_bridge_pkg;

  localparam int WORD_AW = 13;
  localparam int HALF_AW = 14;
  localparam int HALF_W  = 16;
  localparam int WORD_W  = 32;
  localparam int STRB_W  = 4;
  localparam int MASK_W  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    TAIL = 3'd3,
    RESP = 3'd4
  } state_t;

  // Each byte strobe enables the two nibbles of its byte within a halfword.
  function automatic logic [MASK_W-1:0] strb_to_nibmask(input logic [1:0] strb);
    return {strb[1], strb[1], strb[0], strb[0]};
  endfunction

endpackage

// File: rtl/spram_word_bridge.sv
// Splits each 32-bit word request into two halfword SPRAM beats (low half first)
// and returns one response per request after a fixed three-cycle latency.
module spram_word_bridge
  import spram_bridge_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WORD_AW-1:0] req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  input  logic [STRB_W-1:0]  req_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_rdata,
  output logic [HALF_AW-1:0] sram_addr,
  output logic               sram_we,
  output logic [MASK_W-1:0]  sram_mask,
  output logic [HALF_W-1:0]  sram_wdata,
  input  logic [HALF_W-1:0]  sram_rdata
);

  state_t state_r;
  state_t state_s;

  logic               write_r;
  logic [WORD_AW-1:0] addr_r;
  logic [WORD_W-1:0]  wdata_r;
  logic [STRB_W-1:0]  wstrb_r;
  logic [WORD_W-1:0]  rdata_r;

  logic               req_ready_r;
  logic               rsp_valid_r;
  logic [HALF_AW-1:0] sram_addr_r;
  logic               sram_we_r;
  logic [MASK_W-1:0]  sram_mask_r;
  logic [HALF_W-1:0]  sram_wdata_r;

  logic [HALF_AW-1:0] sram_addr_s;
  logic               sram_we_s;
  logic [MASK_W-1:0]  sram_mask_s;
  logic [HALF_W-1:0]  sram_wdata_s;
  logic               accept_s;

  assign accept_s = req_ready_r & req_valid & (state_r == IDLE);

  // Next state plus the SPRAM beat that the next state will present.
  always_comb begin
    state_s      = state_r;
    sram_addr_s  = {HALF_AW{1'b0}};
    sram_we_s    = 1'b0;
    sram_mask_s  = {MASK_W{1'b0}};
    sram_wdata_s = {HALF_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s      = LO;
          sram_addr_s  = {req_addr, 1'b0};
          sram_we_s    = req_write;
          sram_mask_s  = req_write ? strb_to_nibmask(req_wstrb[1:0]) : {MASK_W{1'b0}};
          sram_wdata_s = req_wdata[HALF_W-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        state_s      = HI;
        sram_addr_s  = {addr_r, 1'b1};
        sram_we_s    = write_r;
        sram_mask_s  = write_r ? strb_to_nibmask(wstrb_r[3:2]) : {MASK_W{1'b0}};
        sram_wdata_s = wdata_r[WORD_W-1:HALF_W];
      end
      HI: begin
        state_s = TAIL;
      end
      TAIL: begin
        state_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, so the SPRAM pins change only on clock or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      sram_addr_r  <= {HALF_AW{1'b0}};
      sram_we_r    <= 1'b0;
      sram_mask_r  <= {MASK_W{1'b0}};
      sram_wdata_r <= {HALF_W{1'b0}};
    end else begin
      req_ready_r  <= (state_s == IDLE);
      rsp_valid_r  <= (state_s == RESP);
      sram_addr_r  <= sram_addr_s;
      sram_we_r    <= sram_we_s;
      sram_mask_r  <= sram_mask_s;
      sram_wdata_r <= sram_wdata_s;
    end
  end

  // Request capture; the req_* inputs matter only on the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_r <= 1'b0;
      addr_r  <= {WORD_AW{1'b0}};
      wdata_r <= {WORD_W{1'b0}};
      wstrb_r <= {STRB_W{1'b0}};
    end else if (accept_s) begin
      write_r <= req_write;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
    end else begin
      write_r <= write_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // SPRAM data lags its beat by one cycle: low half arrives during HI, high during TAIL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (state_r == HI) begin
      rdata_r[HALF_W-1:0] <= write_r ? {HALF_W{1'b0}} : sram_rdata;
    end else if (state_r == TAIL) begin
      rdata_r[WORD_W-1:HALF_W] <= write_r ? {HALF_W{1'b0}} : sram_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rdata_r;
  assign sram_addr  = sram_addr_r;
  assign sram_we    = sram_we_r;
  assign sram_mask  = sram_mask_r;
  assign sram_wdata = sram_wdata_r;

endmodule
